reorder_buffer: RTL and testbench

- Circular in-order retirement queue between the decoder and the register file.
- Allocates one entry per issued instruction, tagged by its PC.
- Collects results from the execution units by tag match and retires the head entry in order.
- Drives the register file commit/exception interface: commit strobe, rd, data, PC tag, flush. On a mispredict or exception at the head it flushes everything and redirects fetch.

---
 rtl/reorder_buffer_pkg.sv | 28 ++
 rtl/reorder_buffer.sv | 163 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry payload for the reorder buffer and its neighbours
// (decoder, RS/SLB size their tags from ROB_DEPTH / ROB_PTR_WIDTH).
package reorder_buffer_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned PC_WIDTH      = 32;
  localparam int unsigned RD_WIDTH      = 5;
  localparam int unsigned ROB_DEPTH     = 16;
  localparam int unsigned ROB_PTR_WIDTH = 4;
  localparam int unsigned ROB_CNT_WIDTH = ROB_PTR_WIDTH + 1;

  typedef logic [ROB_PTR_WIDTH-1:0] rob_ptr_t;
  typedef logic [ROB_CNT_WIDTH-1:0] rob_cnt_t;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic                  exc;
    logic [PC_WIDTH-1:0]   pc;
    logic [RD_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0] data;
    logic [PC_WIDTH-1:0]   target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates on issue, matches results by PC tag,
// retires the head in order and flushes/redirects on a faulting head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_empty_from_decoder,
  input  logic [PC_WIDTH-1:0]   pc_from_decoder,
  input  logic [RD_WIDTH-1:0]   rd_from_decoder,
  input  logic                  is_valid_from_ex,
  input  logic [PC_WIDTH-1:0]   pc_from_ex,
  input  logic [DATA_WIDTH-1:0] data_from_ex,
  input  logic                  is_exception_from_ex,
  input  logic [PC_WIDTH-1:0]   target_pc_from_ex,
  output logic                  is_full_to_decoder,
  output logic                  is_commit_to_rf,
  output logic                  is_exception_to_rf,
  output logic [PC_WIDTH-1:0]   pc_to_rf,
  output logic [RD_WIDTH-1:0]   rd_to_rf,
  output logic [DATA_WIDTH-1:0] data_to_rf,
  output logic                  is_redirect_to_fetch,
  output logic [PC_WIDTH-1:0]   pc_to_fetch
);

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];
  rob_ptr_t   head_q, head_d;
  rob_ptr_t   tail_q, tail_d;
  rob_cnt_t   count_q, count_d;

  logic                  commit_q, commit_d;
  logic                  exc_q, exc_d;
  logic                  redirect_q, redirect_d;
  logic [PC_WIDTH-1:0]   pc_rf_q, pc_rf_d;
  logic [RD_WIDTH-1:0]   rd_rf_q, rd_rf_d;
  logic [DATA_WIDTH-1:0] data_rf_q, data_rf_d;
  logic [PC_WIDTH-1:0]   pc_fetch_q, pc_fetch_d;

  logic       wb_hit_c;
  rob_ptr_t   wb_idx_c;
  rob_ptr_t   scan_idx_c;
  logic       issue_c;
  logic       retire_c;
  rob_entry_t head_c;

  // Oldest not-yet-ready busy entry carrying the written-back tag, scanning from head
  always_comb begin
    wb_hit_c   = FALSE;
    wb_idx_c   = '0;
    scan_idx_c = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      scan_idx_c = head_q + ROB_PTR_WIDTH'(i);
      if (!wb_hit_c && is_valid_from_ex && rob_q[scan_idx_c].busy &&
          !rob_q[scan_idx_c].ready && (rob_q[scan_idx_c].pc == pc_from_ex)) begin
        wb_hit_c = TRUE;
        wb_idx_c = scan_idx_c;
      end
    end
  end

  // Next state: writeback, then retire the (possibly just-completed) head, then issue
  always_comb begin
    rob_d      = rob_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    commit_d   = FALSE;
    exc_d      = FALSE;
    redirect_d = FALSE;
    pc_rf_d    = pc_rf_q;
    rd_rf_d    = rd_rf_q;
    data_rf_d  = data_rf_q;
    pc_fetch_d = pc_fetch_q;
    issue_c    = !is_empty_from_decoder && (count_q < ROB_CNT_WIDTH'(ROB_DEPTH));

    if (wb_hit_c) begin
      rob_d[wb_idx_c].ready  = TRUE;
      rob_d[wb_idx_c].data   = data_from_ex;
      rob_d[wb_idx_c].exc    = is_exception_from_ex;
      rob_d[wb_idx_c].target = target_pc_from_ex;
    end

    // A writeback landing on the head retires at this same edge
    head_c   = rob_d[head_q];
    retire_c = head_c.busy && head_c.ready;

    if (retire_c) begin
      commit_d  = TRUE;
      pc_rf_d   = head_c.pc;
      rd_rf_d   = head_c.rd;
      data_rf_d = head_c.data;
    end

    if (retire_c && head_c.exc) begin
      exc_d      = TRUE;
      redirect_d = TRUE;
      pc_fetch_d = head_c.target;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rob_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire_c) begin
        rob_d[head_q] = '0;
        head_d        = head_q + ROB_PTR_WIDTH'(1);
      end
      if (issue_c) begin
        rob_d[tail_q].busy   = TRUE;
        rob_d[tail_q].ready  = FALSE;
        rob_d[tail_q].exc    = FALSE;
        rob_d[tail_q].pc     = pc_from_decoder;
        rob_d[tail_q].rd     = rd_from_decoder;
        rob_d[tail_q].data   = '0;
        rob_d[tail_q].target = '0;
        tail_d               = tail_q + ROB_PTR_WIDTH'(1);
      end
      count_d = count_q + ROB_CNT_WIDTH'(issue_c) - ROB_CNT_WIDTH'(retire_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      commit_q   <= FALSE;
      exc_q      <= FALSE;
      redirect_q <= FALSE;
      pc_rf_q    <= '0;
      rd_rf_q    <= '0;
      data_rf_q  <= '0;
      pc_fetch_q <= '0;
    end else begin
      rob_q      <= rob_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      commit_q   <= commit_d;
      exc_q      <= exc_d;
      redirect_q <= redirect_d;
      pc_rf_q    <= pc_rf_d;
      rd_rf_q    <= rd_rf_d;
      data_rf_q  <= data_rf_d;
      pc_fetch_q <= pc_fetch_d;
    end
  end

  assign is_full_to_decoder   = (count_q == ROB_CNT_WIDTH'(ROB_DEPTH));
  assign is_commit_to_rf      = commit_q;
  assign is_exception_to_rf   = exc_q;
  assign is_redirect_to_fetch = redirect_q;
  assign pc_to_rf             = pc_rf_q;
  assign rd_to_rf             = rd_rf_q;
  assign data_to_rf           = data_rf_q;
  assign pc_to_fetch          = pc_fetch_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based retirement model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        empty_dec = 1'b1;
  logic [31:0] pc_dec = '0;
  logic [4:0]  rd_dec = '0;
  logic        vld_ex = 1'b0;
  logic [31:0] pc_ex = '0;
  logic [31:0] data_ex = '0;
  logic        exc_ex = 1'b0;
  logic [31:0] tgt_ex = '0;

  logic        full_o, commit_o, exc_o, redir_o;
  logic [31:0] pc_rf_o, data_rf_o, pc_fetch_o;
  logic [4:0]  rd_rf_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  reorder_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .is_empty_from_decoder(empty_dec),
    .pc_from_decoder      (pc_dec),
    .rd_from_decoder      (rd_dec),
    .is_valid_from_ex     (vld_ex),
    .pc_from_ex           (pc_ex),
    .data_from_ex         (data_ex),
    .is_exception_from_ex (exc_ex),
    .target_pc_from_ex    (tgt_ex),
    .is_full_to_decoder   (full_o),
    .is_commit_to_rf      (commit_o),
    .is_exception_to_rf   (exc_o),
    .pc_to_rf             (pc_rf_o),
    .rd_to_rf             (rd_rf_o),
    .data_to_rf           (data_rf_o),
    .is_redirect_to_fetch (redir_o),
    .pc_to_fetch          (pc_fetch_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: program-order list of in-flight instructions
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          ready;
    bit          exc;
    logic [31:0] data;
    logic [31:0] target;
  } m_ent_t;

  m_ent_t      mq[$];
  m_ent_t      m_new;
  bit          e_commit, e_exc, e_redir;
  logic [31:0] e_pc, e_data, e_fetch;
  logic [4:0]  e_rd;
  int          m_sz0;
  bit          m_hit, m_flushed;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      e_commit = 0; e_exc = 0; e_redir = 0;
      e_pc = '0; e_rd = '0; e_data = '0; e_fetch = '0;
    end else begin
      m_sz0 = mq.size();
      m_hit = 0;
      m_flushed = 0;
      e_commit = 0; e_exc = 0; e_redir = 0;
      if (vld_ex) begin
        foreach (mq[i]) begin
          if (!m_hit && !mq[i].ready && mq[i].pc == pc_ex) begin
            mq[i].ready = 1; mq[i].exc = exc_ex;
            mq[i].data = data_ex; mq[i].target = tgt_ex;
            m_hit = 1;
          end
        end
      end
      if (mq.size() > 0 && mq[0].ready) begin
        e_commit = 1; e_pc = mq[0].pc; e_rd = mq[0].rd; e_data = mq[0].data;
        if (mq[0].exc) begin
          e_exc = 1; e_redir = 1; e_fetch = mq[0].target;
          mq.delete();
          m_flushed = 1;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (!m_flushed && !empty_dec && m_sz0 < 16) begin
        m_new.pc = pc_dec; m_new.rd = rd_dec; m_new.ready = 0;
        m_new.exc = 0; m_new.data = '0; m_new.target = '0;
        mq.push_back(m_new);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("full",     {31'd0, full_o},   {31'd0, mq.size() == 16});
      check("commit",   {31'd0, commit_o}, {31'd0, e_commit});
      check("exc",      {31'd0, exc_o},    {31'd0, e_exc});
      check("redirect", {31'd0, redir_o},  {31'd0, e_redir});
      check("pc_rf",    pc_rf_o,           e_pc);
      check("rd_rf",    {27'd0, rd_rf_o},  {27'd0, e_rd});
      check("data_rf",  data_rf_o,         e_data);
      check("pc_fetch", pc_fetch_o,        e_fetch);
    end
  end

  task automatic step(input bit e, input logic [31:0] p, input logic [4:0] r,
                      input bit v, input logic [31:0] wp, input logic [31:0] d,
                      input bit x, input logic [31:0] t);
    empty_dec = e; pc_dec = p; rd_dec = r;
    vld_ex = v; pc_ex = wp; data_ex = d; exc_ex = x; tgt_ex = t;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input logic [31:0] p, input logic [4:0] r);
    step(0, p, r, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input logic [31:0] p, input logic [31:0] d);
    step(1, 0, 0, 1, p, d, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    do_reset();

    // Reset and idle
    check("rst_full",   {31'd0, full_o},   32'd0);
    check("rst_commit", {31'd0, commit_o}, 32'd0);
    check("rst_data",   data_rf_o,         32'd0);
    repeat (10) idle();

    // Single instruction: commit two cycles after issue
    issue(32'h4, 5'd3);
    check("single_early", {31'd0, commit_o}, 32'd0);
    wb(32'h4, 32'h55);
    check("single_commit", {31'd0, commit_o}, 32'd1);
    check("single_rd",     {27'd0, rd_rf_o},  32'd3);
    check("single_data",   data_rf_o,         32'h55);
    check("single_pc",     pc_rf_o,           32'h4);
    idle();
    check("single_strobe", {31'd0, commit_o}, 32'd0);
    check("single_hold",   data_rf_o,         32'h55);

    // Out-of-order writeback, in-order retirement
    issue(32'h4, 5'd1);
    issue(32'h8, 5'd2);
    issue(32'hC, 5'd3);
    wb(32'hC, 32'hCC);
    wb(32'h8, 32'h88);
    check("ooo_wait", {31'd0, commit_o}, 32'd0);
    wb(32'h4, 32'h44);
    check("ooo_pc0", pc_rf_o, 32'h4);
    idle();
    check("ooo_pc1", pc_rf_o, 32'h8);
    idle();
    check("ooo_pc2", pc_rf_o, 32'hC);
    check("ooo_d2",  data_rf_o, 32'hCC);
    idle();

    // Fill, drop when full, free a slot, wrap tail
    for (int i = 0; i < 16; i++) issue(32'h100 + 32'(i * 4), 5'(i));
    check("fill_full", {31'd0, full_o}, 32'd1);
    issue(32'h200, 5'd9);
    check("fill_drop", {31'd0, full_o}, 32'd1);
    wb(32'h100, 32'hA0);
    check("fill_free",  {31'd0, full_o}, 32'd0);
    check("fill_cpc",   pc_rf_o,         32'h100);
    issue(32'h300, 5'd7);
    check("fill_again", {31'd0, full_o}, 32'd1);
    for (int i = 1; i < 16; i++) wb(32'h100 + 32'(i * 4), 32'hB00 + 32'(i));
    wb(32'h300, 32'h333);
    check("wrap_pc",   pc_rf_o,         32'h300);
    check("wrap_rd",   {27'd0, rd_rf_o}, 32'd7);
    idle();
    wb(32'h200, 32'h1);
    idle();
    check("drop_never", {31'd0, commit_o}, 32'd0);

    // Exception at head flushes younger ready entries and a same-cycle issue
    do_reset();
    issue(32'h10, 5'd1);
    issue(32'h14, 5'd2);
    issue(32'h18, 5'd3);
    issue(32'h1C, 5'd4);
    wb(32'h14, 32'h1);
    wb(32'h18, 32'h2);
    wb(32'h1C, 32'h3);
    step(0, 32'h50, 5'd5, 1, 32'h10, 32'h77, 1, 32'h40);
    check("exc_commit", {31'd0, commit_o}, 32'd1);
    check("exc_exc",    {31'd0, exc_o},    32'd1);
    check("exc_redir",  {31'd0, redir_o},  32'd1);
    check("exc_fetch",  pc_fetch_o,        32'h40);
    check("exc_pc",     pc_rf_o,           32'h10);
    check("exc_data",   data_rf_o,         32'h77);
    repeat (3) idle();
    check("exc_quiet",  {31'd0, commit_o}, 32'd0);
    wb(32'h50, 32'h9);
    check("exc_gone",   {31'd0, commit_o}, 32'd0);
    check("exc_fhold",  pc_fetch_o,        32'h40);

    // Duplicate tags: oldest first
    issue(32'h20, 5'd1);
    issue(32'h20, 5'd2);
    wb(32'h20, 32'hA);
    check("dup_rd0",   {27'd0, rd_rf_o}, 32'd1);
    check("dup_d0",    data_rf_o,        32'hA);
    idle();
    check("dup_wait",  {31'd0, commit_o}, 32'd0);
    wb(32'h20, 32'hB);
    check("dup_rd1",   {27'd0, rd_rf_o}, 32'd2);
    check("dup_d1",    data_rf_o,        32'hB);

    // Same-cycle issue and writeback of one tag: writeback ignored
    step(0, 32'h30, 5'd6, 1, 32'h30, 32'hE, 0, 0);
    idle();
    check("same_cyc", {31'd0, commit_o}, 32'd0);

    // Reset while an entry is pending
    do_reset();
    wb(32'h30, 32'hF);
    check("midrst", {31'd0, commit_o}, 32'd0);
    repeat (2) idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
